// File: rtl/opcode_decoder.sv
// Byte-serial x86-style instruction decoder: walks prefix/opcode/ModRM/SIB/disp/imm
// bytes under a valid/ready handshake and presents one decoded instruction at a time.
module opcode_decoder #(
    parameter int unsigned MAX_LEN = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic [7:0]  info_addr,
    input  logic [22:0] info_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [7:0]  dec_opcode,
    output logic [22:0] dec_info,
    output logic [3:0]  dec_rex,
    output logic [7:0]  dec_modrm,
    output logic [7:0]  dec_sib,
    output logic [31:0] dec_disp,
    output logic [63:0] dec_imm,
    output logic [4:0]  dec_len,
    output logic        dec_illegal
);

    localparam int unsigned LEN_W  = 5;
    localparam int unsigned INFO_W = 23;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [2:0] {S_OPC, S_MODRM, S_SIB, S_DISP, S_IMM, S_EMIT} state_t;

    state_t              state_q, state_d;
    logic [7:0]          opcode_q, modrm_q, sib_q;
    logic [INFO_W-1:0]   info_q;
    logic [3:0]          rex_q;
    logic [31:0]         disp_q;
    logic [63:0]         imm_q;
    logic [LEN_W-1:0]    len_q;
    logic                illegal_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                disp4_q;

    logic                fire_c;
    logic                is_rex_c;
    logic [LEN_W-1:0]    len_nx_c;
    logic [CNT_W-1:0]    disp_last_c;
    logic [CNT_W-1:0]    imm_last_c;
    state_t              post_ops_c;

    // Operand 1 is considered when numop>=1, operand 2 when numop>=2.
    function automatic logic f_need_modrm(input logic [INFO_W-1:0] inf);
        return ((inf[22:21] != 2'd0) && !inf[20]) || ((inf[22:21] >= 2'd2) && !inf[18]);
    endfunction

    function automatic logic f_imm1(input logic [INFO_W-1:0] inf);
        return (inf[22:21] != 2'd0) && (inf[20:19] == 2'b10);
    endfunction

    function automatic logic f_imm2(input logic [INFO_W-1:0] inf);
        return (inf[22:21] >= 2'd2) && (inf[18:17] == 2'b10);
    endfunction

    function automatic logic [CNT_W-1:0] f_imm_last(input logic [INFO_W-1:0] inf);
        logic [1:0] sz;
        sz = f_imm1(inf) ? inf[16:15] : inf[14:13];
        case (sz)
            2'b00:   return 3'd0;
            2'b01:   return 3'd1;
            2'b10:   return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    assign info_addr   = byte_data;
    assign fire_c      = byte_valid && byte_ready;
    assign is_rex_c    = (byte_data[7:4] == 4'h4);
    assign len_nx_c    = (len_q == 5'd31) ? len_q : len_q + 5'd1;
    assign disp_last_c = disp4_q ? 3'd3 : 3'd0;
    assign imm_last_c  = f_imm_last(info_q);
    assign post_ops_c  = (f_imm1(info_q) || f_imm2(info_q)) ? S_IMM : S_EMIT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_OPC;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_OPC: if (fire_c && !is_rex_c) begin
                if (info_data[22:21] == 2'd0)      state_d = S_EMIT;
                else if (f_need_modrm(info_data))  state_d = S_MODRM;
                else if (f_imm1(info_data) || f_imm2(info_data)) state_d = S_IMM;
                else                               state_d = S_EMIT;
            end
            S_MODRM: if (fire_c) begin
                if (byte_data[7:6] != 2'b11 && byte_data[2:0] == 3'b100) state_d = S_SIB;
                else if (byte_data[7:6] == 2'b01 || byte_data[7:6] == 2'b10) state_d = S_DISP;
                else if (byte_data[7:6] == 2'b00 && byte_data[2:0] == 3'b101) state_d = S_DISP;
                else state_d = post_ops_c;
            end
            S_SIB: if (fire_c) begin
                if (modrm_q[7:6] == 2'b01 || modrm_q[7:6] == 2'b10) state_d = S_DISP;
                else if (modrm_q[7:6] == 2'b00 && byte_data[2:0] == 3'b101) state_d = S_DISP;
                else state_d = post_ops_c;
            end
            S_DISP: if (fire_c && cnt_q == disp_last_c) state_d = post_ops_c;
            S_IMM:  if (fire_c && cnt_q == imm_last_c)  state_d = S_EMIT;
            S_EMIT: if (dec_ready) state_d = S_OPC;
            default: state_d = S_OPC;
        endcase
    end

    always_comb begin
        byte_ready = 1'b1;
        dec_valid  = 1'b0;
        if (state_q == S_EMIT) begin
            byte_ready = 1'b0;
            dec_valid  = 1'b1;
        end
    end

    // Field capture; everything clears when the consumer takes the instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q  <= '0;
            info_q    <= '0;
            rex_q     <= '0;
            modrm_q   <= '0;
            sib_q     <= '0;
            disp_q    <= '0;
            imm_q     <= '0;
            len_q     <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            disp4_q   <= 1'b0;
        end else if (state_q == S_EMIT) begin
            if (dec_ready) begin
                opcode_q  <= '0;
                info_q    <= '0;
                rex_q     <= '0;
                modrm_q   <= '0;
                sib_q     <= '0;
                disp_q    <= '0;
                imm_q     <= '0;
                len_q     <= '0;
                illegal_q <= 1'b0;
                cnt_q     <= '0;
                disp4_q   <= 1'b0;
            end
        end else if (fire_c) begin
            len_q     <= len_nx_c;
            illegal_q <= illegal_q || (32'(len_nx_c) > MAX_LEN);
            case (state_q)
                S_OPC: begin
                    if (is_rex_c) begin
                        rex_q <= byte_data[3:0];
                    end else begin
                        opcode_q <= byte_data;
                        info_q   <= info_data;
                        if (info_data[22:21] == 2'd0) illegal_q <= 1'b1;
                    end
                end
                S_MODRM: begin
                    modrm_q <= byte_data;
                    disp4_q <= (byte_data[7:6] == 2'b10) ||
                               (byte_data[7:6] == 2'b00 && byte_data[2:0] == 3'b101);
                end
                S_SIB: begin
                    sib_q   <= byte_data;
                    disp4_q <= (modrm_q[7:6] == 2'b10) ||
                               (modrm_q[7:6] == 2'b00 && byte_data[2:0] == 3'b101);
                end
                S_DISP: begin
                    if (disp4_q) disp_q[{cnt_q[1:0], 3'b000} +: 8] <= byte_data;
                    else         disp_q <= {{24{byte_data[7]}}, byte_data};
                    cnt_q <= (cnt_q == disp_last_c) ? 3'd0 : cnt_q + 3'd1;
                end
                S_IMM: begin
                    imm_q[{cnt_q, 3'b000} +: 8] <= byte_data;
                    cnt_q <= (cnt_q == imm_last_c) ? 3'd0 : cnt_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign dec_opcode  = opcode_q;
    assign dec_info    = info_q;
    assign dec_rex     = rex_q;
    assign dec_modrm   = modrm_q;
    assign dec_sib     = sib_q;
    assign dec_disp    = disp_q;
    assign dec_imm     = imm_q;
    assign dec_len     = len_q;
    assign dec_illegal = illegal_q;

endmodule

// File: tb/tb_opcode_decoder.sv
// Directed bench for opcode_decoder: expected decodes are queued as each byte
// stream is driven and popped when the decoder presents the instruction.
module tb_opcode_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [7:0]  info_addr;
    logic [22:0] info_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [7:0]  dec_opcode;
    logic [22:0] dec_info;
    logic [3:0]  dec_rex;
    logic [7:0]  dec_modrm;
    logic [7:0]  dec_sib;
    logic [31:0] dec_disp;
    logic [63:0] dec_imm;
    logic [4:0]  dec_len;
    logic        dec_illegal;

    typedef struct packed {
        logic [7:0]  op;
        logic [22:0] info;
        logic [3:0]  rex;
        logic [7:0]  modrm;
        logic [7:0]  sib;
        logic [31:0] disp;
        logic [63:0] imm;
        logic [4:0]  len;
        logic        ill;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] bq[$];
    int         n_checks = 0;
    int         n_errors = 0;

    opcode_decoder #(.MAX_LEN(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .info_addr(info_addr), .info_data(info_data),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_opcode(dec_opcode), .dec_info(dec_info), .dec_rex(dec_rex),
        .dec_modrm(dec_modrm), .dec_sib(dec_sib), .dec_disp(dec_disp),
        .dec_imm(dec_imm), .dec_len(dec_len), .dec_illegal(dec_illegal)
    );

    always #5 clk = ~clk;

    // Fields: numop, op1, op2, sz1, sz2, r1, r2, grp
    function automatic logic [22:0] info_of(input logic [7:0] op);
        case (op)
            8'h01:   return {2'd2, 2'b01, 2'b00, 2'b10, 2'b10, 4'd0, 4'd0, 5'd1};
            8'h05:   return {2'd2, 2'b11, 2'b10, 2'b10, 2'b10, 4'd0, 4'd0, 5'd1};
            8'h50:   return {2'd1, 2'b11, 2'b00, 2'b11, 2'b00, 4'd0, 4'd0, 5'd2};
            8'h6A:   return {2'd1, 2'b10, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 5'd2};
            8'h81:   return {2'd2, 2'b01, 2'b10, 2'b10, 2'b10, 4'd0, 4'd0, 5'd3};
            8'hB8:   return {2'd2, 2'b11, 2'b10, 2'b11, 2'b11, 4'd1, 4'd0, 5'd4};
            default: return 23'd0;
        endcase
    endfunction

    assign info_data = info_of(info_addr);

    function automatic exp_t mk(input logic [7:0] op, input logic [3:0] rex,
                                input logic [7:0] modrm, input logic [7:0] sib,
                                input logic [31:0] disp, input logic [63:0] imm,
                                input logic [4:0] len, input logic ill);
        exp_t e;
        e.op = op; e.info = info_of(op); e.rex = rex; e.modrm = modrm; e.sib = sib;
        e.disp = disp; e.imm = imm; e.len = len; e.ill = ill;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_fields(input string tag, input exp_t e);
        chk({tag, ".valid"},   64'(dec_valid),   64'(1'b1));
        chk({tag, ".bready"},  64'(byte_ready),  64'(1'b0));
        chk({tag, ".opcode"},  64'(dec_opcode),  64'(e.op));
        chk({tag, ".info"},    64'(dec_info),    64'(e.info));
        chk({tag, ".rex"},     64'(dec_rex),     64'(e.rex));
        chk({tag, ".modrm"},   64'(dec_modrm),   64'(e.modrm));
        chk({tag, ".sib"},     64'(dec_sib),     64'(e.sib));
        chk({tag, ".disp"},    64'(dec_disp),    64'(e.disp));
        chk({tag, ".imm"},     dec_imm,          e.imm);
        chk({tag, ".len"},     64'(dec_len),     64'(e.len));
        chk({tag, ".illegal"}, 64'(dec_illegal), 64'(e.ill));
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        w = 0;
        while (!byte_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w == 20) chk("byte_ready_timeout", 64'(byte_ready), 64'(1'b1));
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    // Optional stall of 'gap' idle cycles before byte index gap_idx.
    task automatic send_bq(input int gap_idx, input int gap);
        for (int i = 0; i < bq.size(); i++) begin
            if (i == gap_idx) begin
                repeat (gap) begin
                    @(negedge clk);
                    chk("stall.valid", 64'(dec_valid), 64'(1'b0));
                end
            end
            send_byte(bq[i]);
        end
    endtask

    // Output must be present the cycle after the last byte, then held for 'hold' cycles.
    task automatic collect(input string tag, input int hold);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue"}, 64'(exp_q.size()), 64'd1);
            return;
        end
        e = exp_q.pop_front();
        @(negedge clk);
        chk_fields(tag, e);
        repeat (hold) begin
            @(negedge clk);
            chk_fields({tag, ".hold"}, e);
        end
        dec_ready = 1'b1;
        @(posedge clk);
        #1 dec_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".clr_valid"}, 64'(dec_valid),  64'(1'b0));
        chk({tag, ".clr_len"},   64'(dec_len),    64'd0);
        chk({tag, ".clr_op"},    64'(dec_opcode), 64'd0);
        chk({tag, ".bready"},    64'(byte_ready), 64'(1'b1));
    endtask

    initial begin
        rst_n = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; dec_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.valid", 64'(dec_valid), 64'(1'b0));
        chk("rst.len",   64'(dec_len),   64'd0);
        chk("rst.imm",   dec_imm,        64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.bready", 64'(byte_ready), 64'(1'b1));

        exp_q.push_back(mk(8'h05, 4'h8, 8'h00, 8'h00, 32'h0, 64'h12345678, 5'd6, 1'b0));
        bq = '{8'h48, 8'h05, 8'h78, 8'h56, 8'h34, 8'h12};
        send_bq(-1, 0);
        collect("rex_imm32", 0);

        exp_q.push_back(mk(8'h01, 4'h0, 8'hC3, 8'h00, 32'h0, 64'h0, 5'd2, 1'b0));
        bq = '{8'h01, 8'hC3};
        send_bq(-1, 0);
        collect("modrm_reg", 0);

        exp_q.push_back(mk(8'h01, 4'h0, 8'h44, 8'h24, 32'h8, 64'h0, 5'd4, 1'b0));
        bq = '{8'h01, 8'h44, 8'h24, 8'h08};
        send_bq(-1, 0);
        collect("sib_disp8", 0);

        exp_q.push_back(mk(8'h01, 4'h0, 8'h45, 8'h00, 32'hFFFFFFF8, 64'h0, 5'd3, 1'b0));
        bq = '{8'h01, 8'h45, 8'hF8};
        send_bq(2, 3);
        collect("disp8_neg_stall", 0);

        exp_q.push_back(mk(8'h06, 4'h0, 8'h00, 8'h00, 32'h0, 64'h0, 5'd1, 1'b1));
        bq = '{8'h06};
        send_bq(-1, 0);
        collect("numop0", 0);

        exp_q.push_back(mk(8'h50, 4'h0, 8'h00, 8'h00, 32'h0, 64'h0, 5'd1, 1'b0));
        bq = '{8'h50};
        send_bq(-1, 0);
        @(negedge clk);
        chk("push.r1", 64'(dec_info[12:9]), 64'd0);
        exp_q[0].len = 5'd1;
        dec_ready = 1'b0;
        chk_fields("push", exp_q.pop_front());
        dec_ready = 1'b1;
        @(posedge clk);
        #1 dec_ready = 1'b0;

        exp_q.push_back(mk(8'h01, 4'h0, 8'h05, 8'h00, 32'h12345678, 64'h0, 5'd6, 1'b0));
        bq = '{8'h01, 8'h05, 8'h78, 8'h56, 8'h34, 8'h12};
        send_bq(-1, 0);
        collect("disp32_hold", 3);

        exp_q.push_back(mk(8'h6A, 4'h0, 8'h00, 8'h00, 32'h0, 64'h7F, 5'd2, 1'b0));
        bq = '{8'h6A, 8'h7F};
        send_bq(-1, 0);
        collect("imm8", 0);

        exp_q.push_back(mk(8'hB8, 4'h8, 8'h00, 8'h00, 32'h0, 64'h0807060504030201, 5'd10, 1'b0));
        bq = '{8'h48, 8'hB8, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_bq(-1, 0);
        collect("imm64", 0);

        exp_q.push_back(mk(8'h81, 4'h0, 8'h84, 8'h24, 32'h44332211, 64'hDEADBEEF, 5'd11, 1'b0));
        bq = '{8'h81, 8'h84, 8'h24, 8'h11, 8'h22, 8'h33, 8'h44, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_bq(-1, 0);
        collect("sib_disp32_imm32", 0);

        exp_q.push_back(mk(8'h01, 4'h0, 8'hC3, 8'h00, 32'h0, 64'h0, 5'd15, 1'b0));
        bq.delete();
        repeat (13) bq.push_back(8'h40);
        bq.push_back(8'h01); bq.push_back(8'hC3);
        send_bq(-1, 0);
        collect("len15_legal", 0);

        exp_q.push_back(mk(8'h01, 4'h0, 8'hC3, 8'h00, 32'h0, 64'h0, 5'd16, 1'b1));
        bq.delete();
        repeat (14) bq.push_back(8'h40);
        bq.push_back(8'h01); bq.push_back(8'hC3);
        send_bq(-1, 0);
        collect("len16_illegal", 0);

        exp_q.push_back(mk(8'h01, 4'h1, 8'hC3, 8'h00, 32'h0, 64'h0, 5'd31, 1'b1));
        bq.delete();
        repeat (30) bq.push_back(8'h41);
        bq.push_back(8'h01); bq.push_back(8'hC3);
        send_bq(-1, 0);
        collect("len_saturate", 0);

        bq = '{8'h01, 8'h44};
        send_bq(-1, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.valid", 64'(dec_valid),  64'(1'b0));
        chk("midrst.op",    64'(dec_opcode), 64'd0);
        chk("midrst.info",  64'(dec_info),   64'd0);
        chk("midrst.modrm", 64'(dec_modrm),  64'd0);
        chk("midrst.len",   64'(dec_len),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst.bready", 64'(byte_ready), 64'(1'b1));

        exp_q.push_back(mk(8'h01, 4'h0, 8'hC3, 8'h00, 32'h0, 64'h0, 5'd2, 1'b0));
        bq = '{8'h01, 8'hC3};
        send_bq(-1, 0);
        collect("after_rst", 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
